onehot_arbiter_rr: RTL

- Round-robin, packet-locking arbiter sharing one downstream channel between WIDTH requesters.
- Holds a registered one-hot grant vector; its binary index comes from the team's one-hot encoder and drives the downstream data mux select.
- Grant is held until the last beat of the granted packet transfers; then the priority pointer rotates past the winner.

---
 rtl/arbiter_pkg.sv | 34 +++
 rtl/onehot_encoder_base.sv | 36 +++
 rtl/onehot_arbiter_rr.sv | 89 ++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package arbiter_pkg;

  // Largest requester count the search helper supports.
  localparam int MAX_WIDTH = 32;
  localparam int MAX_LOG   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index of the first set bit of vec[width-1:0], scanning upward from ptr
  // and wrapping from width-1 back to 0. Returns 0 when nothing is set.
  function automatic int unsigned rr_first(input logic [MAX_WIDTH-1:0] vec,
                                           input int unsigned ptr,
                                           input int unsigned width);
    int unsigned pos;
    logic        found;
    rr_first = 0;
    found    = 1'b0;
    for (int unsigned k = 0; k < MAX_WIDTH; k++) begin
      if (k < width && !found) begin
        pos = ptr + k;
        if (pos >= width) pos = pos - width;
        if (vec[pos[MAX_LOG-1:0]]) begin
          rr_first = pos;
          found    = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/onehot_encoder_base.sv
// One-hot to binary encoder; table (OR-of-masks) or loop implementation.
module onehot_encoder_base #(
  parameter  int WIDTH          = 4,
  parameter  int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     oht,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 enc_vld
);

  // Requester positions whose binary index has bit b set.
  function automatic logic [WIDTH-1:0] bit_mask(input int b);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) m[i] = 1'((i >> b) & 1);
    return m;
  endfunction

  assign enc_vld = |oht;

  if (IMPLEMENTATION == 0) begin : g_table
    // Each index bit is the OR of the one-hot positions that carry it.
    for (genvar b = 0; b < WIDTH_LOG; b++) begin : g_bit
      assign idx[b] = |(oht & bit_mask(b));
    end
  end else begin : g_loop
    // OR together the indices of all set bits (exactly one for valid input).
    always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (oht[i]) idx = idx | WIDTH_LOG'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_arbiter_rr.sv
// Round-robin, packet-locking arbiter onto a single downstream channel.
module onehot_arbiter_rr
  import arbiter_pkg::*;
#(
  parameter  int WIDTH          = 4,
  parameter  int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req_vld,
  input  logic [WIDTH-1:0]     req_lst,
  output logic [WIDTH-1:0]     req_rdy,
  output logic [WIDTH-1:0]     gnt_oht,
  output logic [WIDTH_LOG-1:0] gnt_idx,
  output logic                 gnt_vld,
  output logic                 out_vld,
  output logic                 out_lst,
  input  logic                 out_rdy
);

  arb_state_t           state, state_nxt;
  logic [WIDTH_LOG-1:0] ptr, ptr_nxt;
  logic [WIDTH-1:0]     gnt_nxt;
  int unsigned          win;
  logic                 enc_vld;

  onehot_encoder_base #(
    .WIDTH          (WIDTH),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_enc (
    .oht     (gnt_oht),
    .idx     (gnt_idx),
    .enc_vld (enc_vld)
  );

  assign gnt_vld = (state == BUSY);

  // State, priority pointer and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_oht <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_oht <= gnt_nxt;
    end
  end

  // Arbitration in IDLE, packet forwarding and release in BUSY.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_oht;
    req_rdy   = '0;
    out_vld   = 1'b0;
    out_lst   = 1'b0;
    win       = rr_first(MAX_WIDTH'(req_vld), 32'(ptr), 32'(WIDTH));
    unique case (state)
      IDLE: begin
        if (|req_vld) begin
          gnt_nxt   = WIDTH'(1) << win;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        out_vld = |(req_vld & gnt_oht);
        out_lst = |(req_lst & gnt_oht);
        req_rdy = gnt_oht & {WIDTH{out_rdy}};
        if (out_vld && out_rdy && out_lst) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = (gnt_idx == WIDTH_LOG'(WIDTH - 1)) ? '0
                                                         : gnt_idx + WIDTH_LOG'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_oht));
  a_gnt_vld     : assert property (@(posedge clk) disable iff (rst) gnt_vld == enc_vld);
  a_rdy_granted : assert property (@(posedge clk) disable iff (rst) (req_rdy & ~gnt_oht) == '0);

endmodule
